// File: rtl/video_pkg.sv
// Shared types and constants for the video timing decoder.
package video_pkg;

   localparam int VID_XW = 11;
   localparam int VID_YW = 11;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SYNC     = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   // Bit positions inside the 9-bit {pixel, de, h_sync, v_sync} bundle carried by the delay lines
   localparam int STREAM_W   = 9;
   localparam int IDX_VS     = 0;
   localparam int IDX_HS     = 1;
   localparam int IDX_DE     = 2;
   localparam int IDX_PIX_LO = 3;
   localparam int IDX_PIX_HI = 8;

endpackage

// File: rtl/video_timing_decoder_edge_detect.sv
// Single-bit edge detector. Rise and fall are measured against the previous
// sample that was taken on a ce-qualified cycle.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= 1'b0;
      else if (ce)
         q <= d;
   end

   assign rise = d & ~q;
   assign fall = ~d & q;

endmodule

// File: rtl/video_timing_decoder.sv
// Pixel-stream timing decoder: x/y position, frame measurement and lock tracking.
// Optional h_sync count check is enabled by defining VIDEO_TIMING_HSYNC_CHECK_EN.
//
// state    | meaning
// UNLOCKED | no v_sync seen since reset; positions not reported
// SYNC     | framing known, waiting for two matching frames
// LOCKED   | last two frames agreed and every line matched the first
module video_timing_decoder
   import video_pkg::*;
#(
   parameter int XW = VID_XW,
   parameter int YW = VID_YW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          de,
   input  logic          h_sync,
   input  logic          v_sync,
`ifdef VIDEO_TIMING_HSYNC_CHECK_EN
   output logic          hsync_err,
`endif
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          pos_valid,
   output logic          line_start,
   output logic          frame_start,
   output logic          locked,
   output logic [XW-1:0] width_meas,
   output logic [YW-1:0] height_meas
);

   state_t        state, state_nxt;
   logic          de_rise, de_fall, v_rise, v_fall_unused;
   logic [XW-1:0] x_cnt, x_nxt, frame_w, frame_w_nxt, line_w;
   logic [YW-1:0] y_cnt, y_nxt;
   logic          have_w, have_w_nxt, w_err, w_err_nxt, fs_pend, fs_pend_nxt;
   logic          match, meas_upd, valid, hs_bad;

   edge_detect u_de (.clk(clk), .rst(rst), .ce(ce), .d(de),     .rise(de_rise), .fall(de_fall));
   edge_detect u_vs (.clk(clk), .rst(rst), .ce(ce), .d(v_sync), .rise(v_rise),  .fall(v_fall_unused));

`ifdef VIDEO_TIMING_HSYNC_CHECK_EN
   logic          h_rise, h_fall_unused;
   logic [YW-1:0] hs_cnt;

   edge_detect u_hs (.clk(clk), .rst(rst), .ce(ce), .d(h_sync), .rise(h_rise), .fall(h_fall_unused));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_cnt    <= '0;
         hsync_err <= 1'b0;
      end else if (ce) begin
         if (v_rise)
            hs_cnt <= h_rise ? YW'(1) : '0;
         else if (h_rise && !(&hs_cnt))
            hs_cnt <= hs_cnt + 1'b1;
         hsync_err <= meas_upd && hs_bad;
      end
   end

   assign hs_bad = (hs_cnt < y_cnt);
`else
   logic hs_unused;
   assign hs_unused = h_sync;
   assign hs_bad    = 1'b0;
`endif

   always_comb begin
      line_w      = (&x_cnt) ? x_cnt : x_cnt + 1'b1;
      x_nxt       = x_cnt;
      y_nxt       = y_cnt;
      frame_w_nxt = frame_w;
      have_w_nxt  = have_w;
      w_err_nxt   = w_err;
      fs_pend_nxt = fs_pend;
      state_nxt   = state;

      if (de_rise)
         x_nxt = '0;
      else if (de && !(&x_cnt))
         x_nxt = x_cnt + 1'b1;

      // v_rise wins over a coinciding de_rise: that pixel becomes (0,0)
      if (v_rise)
         y_nxt = '0;
      else if (de_fall && !(&y_cnt))
         y_nxt = y_cnt + 1'b1;

      if (v_rise) begin
         frame_w_nxt = '0;
         have_w_nxt  = 1'b0;
         w_err_nxt   = 1'b0;
      end else if (de_fall) begin
         if (!have_w) begin
            frame_w_nxt = line_w;
            have_w_nxt  = 1'b1;
         end else if (line_w != frame_w) begin
            w_err_nxt = 1'b1;
         end
      end

      if (de_rise)
         fs_pend_nxt = 1'b0;
      else if (v_rise)
         fs_pend_nxt = 1'b1;

      match    = have_w && !w_err && !hs_bad &&
                 (frame_w == width_meas) && (y_cnt == height_meas);
      meas_upd = v_rise && (state != UNLOCKED) && have_w;

      case (state)
         UNLOCKED: if (v_rise) state_nxt = SYNC;
         SYNC:     if (v_rise && match) state_nxt = LOCKED;
         LOCKED: begin
            if (v_rise) begin
               if (!match) state_nxt = SYNC;
            end else if (de_fall && have_w && (line_w != frame_w)) begin
               state_nxt = SYNC;
            end
         end
         default:  state_nxt = UNLOCKED;
      endcase

      valid = de && (state_nxt != UNLOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= UNLOCKED;
         x_cnt       <= '0;
         y_cnt       <= '0;
         frame_w     <= '0;
         have_w      <= 1'b0;
         w_err       <= 1'b0;
         fs_pend     <= 1'b0;
         x           <= '0;
         y           <= '0;
         pos_valid   <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         width_meas  <= '0;
         height_meas <= '0;
      end else if (ce) begin
         state       <= state_nxt;
         x_cnt       <= x_nxt;
         y_cnt       <= y_nxt;
         frame_w     <= frame_w_nxt;
         have_w      <= have_w_nxt;
         w_err       <= w_err_nxt;
         fs_pend     <= fs_pend_nxt;
         x           <= valid ? x_nxt : '0;
         y           <= valid ? y_nxt : '0;
         pos_valid   <= valid;
         line_start  <= valid && de_rise;
         frame_start <= valid && de_rise && (fs_pend || v_rise);
         if (meas_upd) begin
            width_meas  <= frame_w;
            height_meas <= y_cnt;
         end
      end
   end

   assign locked = (state == LOCKED);

endmodule
